mtm_alu_deserializer: RTL

Serial input front end of the ALU. It sits between the `sin` pin and the arithmetic core.
- Decodes 11-bit frames from `sin`.
- Assembles operands B and A from eight data packets.
- Checks the command packet for packet-count, CRC and opcode errors.
- Presents one parsed request (operands and op, or an error set) to the core as a single-cycle valid pulse.

---
 rtl/mtm_alu_pkg.sv | 47 ++++
 rtl/mtm_alu_crc4.sv | 11 +
 rtl/mtm_alu_deserializer.sv | 105 ++++++++++
 3 files changed

// File: rtl/mtm_alu_pkg.sv
// Shared types and helpers for the ALU serial front end and output stage.
package mtm_alu_pkg;

  localparam int FRAME_BITS = 11;
  localparam int DATA_PKTS  = 8;

  localparam logic PKT_DATA = 1'b0;
  localparam logic PKT_CMD  = 1'b1;

  typedef enum logic [2:0] {
    AND = 3'b000,
    OR  = 3'b001,
    ADD = 3'b100,
    SUB = 3'b101
  } operation_t;

  typedef enum logic [1:0] {
    IDLE,
    TYPE,
    PAYLOAD,
    STOP
  } des_state_t;

  typedef struct packed {
    logic err_data;
    logic err_crc;
    logic err_op;
  } err_flags_t;

  // Only the four defined opcodes are accepted by the core.
  function automatic logic op_is_valid(input logic [2:0] op);
    return (op == AND) || (op == OR) || (op == ADD) || (op == SUB);
  endfunction

  // CRC4, poly x^4+x+1, init 0, message consumed MSB first.
  function automatic logic [3:0] crc4_68(input bit [67:0] d);
    logic [3:0] c;
    logic       fb;
    c = '0;
    for (int i = 67; i >= 0; i--) begin
      fb = c[3] ^ d[i];
      c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
    end
    return c;
  endfunction

endpackage

// File: rtl/mtm_alu_crc4.sv
// Combinational CRC4 over {B, A, 1'b1, OP}.
module mtm_alu_crc4
  import mtm_alu_pkg::*;
(
  input  logic [67:0] data,
  output logic [3:0]  crc
);

  assign crc = crc4_68(data);

endmodule

// File: rtl/mtm_alu_deserializer.sv
// Serial frame decoder: gathers operand bytes, validates the command
// packet and emits one request (or error set) per command/framing error.
module mtm_alu_deserializer
  import mtm_alu_pkg::*;
#(
  parameter int DATA_PKTS = 8,
  parameter int CRC_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin,
  output logic [31:0]      a_o,
  output logic [31:0]      b_o,
  output logic [2:0]       op_o,
  output logic [CRC_W-1:0] crc_o,
  output logic             valid_o,
  output logic             err_data_o,
  output logic             err_crc_o,
  output logic             err_op_o
);

  localparam int CNT_W = $clog2(DATA_PKTS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_PKTS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DATA_PKTS + 1);

  des_state_t       state;
  logic             pkt_type;
  logic [2:0]       bit_cnt;
  logic [7:0]       payload;
  logic [63:0]      ba;
  logic [CNT_W-1:0] pkt_cnt;
  err_flags_t       err_q;
  logic [3:0]       crc_calc;
  logic             cnt_bad;

  // CRC covers the accumulated operands, a constant 1 and the received opcode.
  mtm_alu_crc4 u_crc (
    .data ({ba, 1'b1, payload[6:4]}),
    .crc  (crc_calc)
  );

  assign cnt_bad    = (pkt_cnt != CNT_FULL);
  assign err_data_o = err_q.err_data;
  assign err_crc_o  = err_q.err_crc;
  assign err_op_o   = err_q.err_op;

  // Frame FSM; all request outputs are registered on the stop-bit edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pkt_type <= PKT_DATA;
      bit_cnt  <= '0;
      payload  <= '0;
      ba       <= '0;
      pkt_cnt  <= '0;
      err_q    <= '0;
      a_o      <= '0;
      b_o      <= '0;
      op_o     <= '0;
      crc_o    <= '0;
      valid_o  <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      case (state)
        IDLE: if (!sin) state <= TYPE;
        TYPE: begin
          pkt_type <= sin;
          bit_cnt  <= '0;
          state    <= PAYLOAD;
        end
        PAYLOAD: begin
          payload <= {payload[6:0], sin};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state <= STOP;
        end
        STOP: begin
          state <= IDLE;
          if (!sin) begin
            // Framing error: report it and drop any partial request.
            valid_o <= 1'b1;
            err_q   <= '{err_data: 1'b1, err_crc: 1'b0, err_op: 1'b0};
            pkt_cnt <= '0;
          end else if (pkt_type == PKT_DATA) begin
            // Oldest byte ends up in B[31:24], newest in A[7:0].
            ba <= {ba[55:0], payload};
            if (pkt_cnt != CNT_SAT) pkt_cnt <= pkt_cnt + 1'b1;
          end else begin
            valid_o <= 1'b1;
            a_o     <= ba[31:0];
            b_o     <= ba[63:32];
            op_o    <= payload[6:4];
            crc_o   <= CRC_W'(payload[3:0]);
            pkt_cnt <= '0;
            // A wrong packet count masks the CRC and opcode checks.
            err_q   <= '{err_data: cnt_bad,
                         err_crc:  !cnt_bad && (crc_calc != payload[3:0]),
                         err_op:   !cnt_bad && !op_is_valid(payload[6:4])};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
